// File: rtl/gpr_dumper.sv
// gpr_dumper
// Walks a range of register-file indices, reads each register through a
// combinational read port and presents it as one ready/valid entry per
// register. Index 0 always reads as zero, regardless of what the register
// file returns for it.
//
// Parameters
//   DATA_W     register data width
//   ADDR_W     register index width (2**ADDR_W registers)
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      dump request pulse, only looked at while idle
//   cfg_first  first index to dump, latched on an accepted start
//   cfg_last   last index to dump, latched on an accepted start
//   rf_raddr   register file read address (always the current index)
//   rf_rdata   register file read data for rf_raddr, same cycle
//   out_valid  out_idx/out_data/out_last hold an entry
//   out_ready  downstream accepts the entry when out_valid is also high
//   out_data   captured register value
//   out_idx    index of the register in out_data
//   out_last   entry is the final one of the dump
//   busy       a dump (or a rejection) is in progress
//   done       one-cycle pulse when a dump or rejection finishes
//   err        one-cycle pulse alongside done when the range was rejected

module gpr_dumper #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_first,
  input  logic [ADDR_W-1:0] cfg_last,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_q;
  logic              err_flag;

  // The first index only matters at the moment the dump starts, so it is
  // latched straight into the walking index rather than kept separately.
  // The captured entry (out_data/out_idx) only changes in LOAD, which keeps
  // it stable for the whole SEND phase however long the stall lasts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      last_q   <= '0;
      err_flag <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_first <= cfg_last) begin
              idx    <= cfg_first;
              last_q <= cfg_last;
              state  <= LOAD;
            end else begin
              err_flag <= 1'b1;
              state    <= FIN;
            end
          end
        end
        LOAD: begin
          // x0 is hardwired to zero whatever the register file returns.
          out_data <= (idx == '0) ? '0 : rf_rdata;
          out_idx  <= idx;
          state    <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (idx == last_q) begin
              state <= FIN;
            end else begin
              // Cannot wrap: idx is strictly below last_q here.
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
          end
        end
        FIN: begin
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs are pure decodes of registered state, so none of them
  // has a combinational path from an input and all drop with reset.
  assign rf_raddr  = idx;
  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && (out_idx == last_q);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign err       = (state == FIN) && err_flag;

endmodule

// File: tb/tb_gpr_dumper.sv
// tb_gpr_dumper
// Directed, table-driven bench for gpr_dumper. Each table row describes one
// dump request (range, per-entry stall length, whether to fire a stray start
// mid-dump) together with the expected entry count, err value and the cycle
// of the done pulse counted from the accepting edge. A hand-written sequence
// covers reset asserted in the middle of a dump.

module tb_gpr_dumper;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_first;
  logic [AW-1:0] cfg_last;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    int            stall;
    bit            busy_start;
    int            exp_count;
    bit            exp_err;
    int            exp_done_cyc;
  } vec_t;

  vec_t vecs [7];

  gpr_dumper #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_first (cfg_first),
    .cfg_last  (cfg_last),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: x_i = 0x1000 + i, and x0 deliberately returns a
  // nonzero value so the hardwired-zero behaviour is observable.
  assign rf_rdata = (rf_raddr == '0) ? 32'h0000_DEAD : (32'h0000_1000 + {27'b0, rf_raddr});

  function automatic logic [31:0] expData(input int i);
    return (i == 0) ? 32'h0 : (32'h0000_1000 + i);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one dump request, checking every cycle from the accepting edge
  // until the cycle after done.
  task automatic applyStimulus(input vec_t v);
    int cyc;
    int entries;
    int stall_ctr;
    bit in_entry;
    bit finished;
    logic [AW-1:0] hold_idx;
    logic [DW-1:0] hold_data;
    cyc = 1; entries = 0; stall_ctr = 0; in_entry = 0; finished = 0;
    hold_idx = '0; hold_data = '0;
    @(posedge clk); #1;
    cfg_first = v.first;
    cfg_last  = v.last;
    start     = 1'b1;
    out_ready = (v.stall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    while (!finished && cyc < 400) begin
      start = 1'b0;
      checkOutput("busy_during_dump", busy, 1'b1);
      if (out_valid) begin
        if (!in_entry) begin
          in_entry  = 1'b1;
          hold_idx  = out_idx;
          hold_data = out_data;
          checkOutput("entry_idx", out_idx, int'(v.first) + entries);
          checkOutput("entry_data", out_data, expData(int'(v.first) + entries));
          if (entries == 0) checkOutput("first_valid_cycle", cyc, 2);
          else if (v.stall == 0) checkOutput("valid_spacing", cyc, 2 + 2 * entries);
        end else begin
          checkOutput("stall_idx_stable", out_idx, hold_idx);
          checkOutput("stall_data_stable", out_data, hold_data);
        end
        checkOutput("out_last", out_last, (int'(v.first) + entries == int'(v.last)));
        if (v.busy_start && entries == 2) begin
          start     = 1'b1;
          cfg_first = 5'd5;
          cfg_last  = 5'd6;
        end
        if (stall_ctr < v.stall) begin
          out_ready = 1'b0;
          stall_ctr++;
        end else begin
          out_ready = 1'b1;
          stall_ctr = 0;
          entries++;
          in_entry = 1'b0;
        end
      end else begin
        checkOutput("last_low_without_valid", out_last, 1'b0);
        out_ready = (v.stall == 0);
      end
      if (done) begin
        checkOutput("done_cycle", cyc, v.exp_done_cyc);
        checkOutput("err_with_done", err, v.exp_err);
        finished = 1'b1;
      end else begin
        checkOutput("err_without_done", err, 1'b0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checkOutput("done_seen_in_budget", finished, 1'b1);
    checkOutput("entry_count", entries, v.exp_count);
    checkOutput("done_one_cycle", done, 1'b0);
    checkOutput("err_one_cycle", err, 1'b0);
    checkOutput("idle_after_done", busy, 1'b0);
    checkOutput("valid_after_done", out_valid, 1'b0);
  endtask

  initial begin
    int waited;
    bit seen;
    vecs[0] = '{5'd0,  5'd31, 0, 1'b0, 32, 1'b0, 65};
    vecs[1] = '{5'd3,  5'd5,  4, 1'b0, 3,  1'b0, 19};
    vecs[2] = '{5'd7,  5'd7,  0, 1'b0, 1,  1'b0, 3};
    vecs[3] = '{5'd9,  5'd2,  0, 1'b0, 0,  1'b1, 1};
    vecs[4] = '{5'd0,  5'd31, 0, 1'b1, 32, 1'b0, 65};
    vecs[5] = '{5'd30, 5'd31, 1, 1'b0, 2,  1'b0, 7};
    vecs[6] = '{5'd0,  5'd0,  0, 1'b0, 1,  1'b0, 3};

    rst = 1'b1; start = 1'b0; cfg_first = '0; cfg_last = '0; out_ready = 1'b0;
    #12;
    checkOutput("reset_valid", out_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_last", out_last, 1'b0);
    checkOutput("reset_raddr", rf_raddr, 0);
    checkOutput("reset_data", out_data, 0);
    checkOutput("reset_idx", out_idx, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Reset in the middle of SEND for entry 2 of a 0..31 dump.
    @(posedge clk); #1;
    cfg_first = 5'd0; cfg_last = 5'd31; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 20) begin
      if (out_valid && out_idx == 5'd2) begin
        seen = 1'b1;
        out_ready = 1'b0;
      end else begin
        @(posedge clk); #1;
        waited++;
      end
    end
    checkOutput("reached_entry2", seen, 1'b1);
    checkOutput("pre_reset_raddr", rf_raddr, 2);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_valid_drop", out_valid, 1'b0);
    checkOutput("async_busy_drop", busy, 1'b0);
    checkOutput("async_raddr_drop", rf_raddr, 0);
    checkOutput("async_no_done", done, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("post_reset_no_done", done, 1'b0);
      checkOutput("post_reset_idle", busy, 1'b0);
    end
    applyStimulus('{5'd0, 5'd1, 0, 1'b0, 2, 1'b0, 5});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
